// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-client memory line-bus arbiter: command
// encodings, FSM state type and default geometry.
package mem_bus_pkg;

    localparam int DEF_LINE_SIZE      = 16;
    localparam int DEF_ADDR_W         = 14;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        WAIT_RESP,
        DONE
    } state_e;

    // Only READ and WRITE start a burst; the RESP code is never a request.
    function automatic logic is_legal_cmd(input logic [1:0] cmd);
        return (cmd != CMD_NOP) && (cmd != CMD_RESP);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. On a tie the client not granted last wins;
// the last-grant register moves only on the update pulse.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic       pick_valid,
    output logic       pick_idx
);

    logic last_q;

    // Reset value 1 makes client 0 the first tie winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= update_idx;
        end
    end

    always_comb begin
        pick_valid = |req;
        pick_idx   = 1'b0;
        if (req == 2'b11) begin
            pick_idx = ~last_q;
        end else if (req[1]) begin
            pick_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the memory line bus for the I-cache and D-cache.
// Define ARB_TIMEOUT_EN to add the WAIT_RESP response watchdog and mN_err.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = DEF_LINE_SIZE,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_grant,
    output logic              m0_beat,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_grant,
    output logic              m1_beat,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int BEATS = CACHE_LINE_SIZE / 2;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;

    logic [1:0] req;
    logic       pick_valid;
    logic       pick_idx;
    logic       timeout_hit;
    logic       err_flag;

    assign req = {is_legal_cmd(m1_cmd), is_legal_cmd(m0_cmd)};

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .update     (state_q == DONE),
        .update_idx (owner_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == WAIT_RESP) && !mem_resp && (to_cnt_q == TO_LAST);

    // err_q carries the expiry from the last WAIT_RESP cycle into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if ((state_q != WAIT_RESP) || mem_resp) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign err_flag = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_flag    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cmd_d   = pick_idx ? m1_cmd : m0_cmd;
                    addr_d  = pick_idx ? m1_addr : m0_addr;
                    state_d = CMD;
                end
            end
            CMD: begin
                beat_d  = '0;
                state_d = (cmd_q == CMD_WRITE) ? WDATA : WAIT_RESP;
            end
            WDATA: begin
                beat_d = beat_q + CNT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A write needs only the single ack; a read counts data beats.
                if (mem_resp) begin
                    if (cmd_q == CMD_WRITE) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_d = DONE;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic busy;
    logic beat_any;
    logic done_any;
    logic read_phase;

    always_comb begin
        busy       = (state_q != IDLE);
        read_phase = (state_q == WAIT_RESP) && (cmd_q == CMD_READ);
        beat_any   = (state_q == WDATA) || (read_phase && mem_resp);
        done_any   = (state_q == DONE);

        m0_grant = busy & ~owner_q;
        m1_grant = busy & owner_q;
        m0_beat  = beat_any & ~owner_q;
        m1_beat  = beat_any & owner_q;
        m0_done  = done_any & ~owner_q;
        m1_done  = done_any & owner_q;
        m0_err   = done_any & err_flag & ~owner_q;
        m1_err   = done_any & err_flag & owner_q;

        m0_rdata = '0;
        m1_rdata = '0;
        if (read_phase) begin
            if (owner_q) m1_rdata = mem_rdata;
            else         m0_rdata = mem_rdata;
        end

        mem_cmd   = ((state_q == CMD) || (state_q == WDATA)) ? cmd_q : CMD_NOP;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if (state_q == WDATA) begin
            mem_wdata = owner_q ? m1_wdata : m0_wdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writes, round-robin ties, reset
// abort, illegal command and (with ARB_TIMEOUT_EN) the response watchdog.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 16;
    localparam int BEATS   = 8;
    localparam int TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        m0_cmd, m1_cmd;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_grant, m0_beat, m0_done, m0_err;
    logic              m1_grant, m1_beat, m1_done, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    logic [1:0] grant_v, beat_v, done_v, err_v;
    assign grant_v = {m1_grant, m0_grant};
    assign beat_v  = {m1_beat, m0_beat};
    assign done_v  = {m1_done, m0_done};
    assign err_v   = {m1_err, m0_err};

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];

    mem_bus_arbiter #(
        .CACHE_LINE_SIZE (16),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_cmd    (m0_cmd),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_grant  (m0_grant),
        .m0_beat   (m0_beat),
        .m0_rdata  (m0_rdata),
        .m0_done   (m0_done),
        .m0_err    (m0_err),
        .m1_cmd    (m1_cmd),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_grant  (m1_grant),
        .m1_beat   (m1_beat),
        .m1_rdata  (m1_rdata),
        .m1_done   (m1_done),
        .m1_err    (m1_err),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int c, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
        if (c == 0) begin
            m0_cmd  = cmd;
            m0_addr = addr;
        end else begin
            m1_cmd  = cmd;
            m1_addr = addr;
        end
    endtask

    task automatic set_wdata(input int c, input logic [DATA_W-1:0] d);
        if (c == 0) m0_wdata = d;
        else        m1_wdata = d;
    endtask

    function automatic logic [DATA_W-1:0] rdata_of(input int c);
        return (c == 0) ? m0_rdata : m1_rdata;
    endfunction

    // Full read burst for client c; first mem_resp arrives `delay` cycles after CMD.
    task automatic read_burst(input int c, input logic [ADDR_W-1:0] addr, input int delay,
                              input logic [DATA_W-1:0] base, input bit both);
        int sent, got, done_k;
        set_cmd(c, CMD_READ, addr);
        if (both) set_cmd(1 - c, CMD_READ, ~addr);
        #1;
        check("rd_idle_grant", grant_v, 2'b00);
        step();
        m0_cmd = CMD_NOP;
        m1_cmd = CMD_NOP;
        #1;
        check("rd_cmd_grant", grant_v, (c == 0) ? 2'b01 : 2'b10);
        check("rd_cmd_mem_cmd", mem_cmd, CMD_READ);
        check("rd_cmd_addr", mem_addr, addr);
        exp_q.delete();
        for (int i = 0; i < BEATS; i++) exp_q.push_back(base + DATA_W'(i));
        sent   = 0;
        got    = 0;
        done_k = 0;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            step();
            mem_resp  = (k >= delay) && (sent < BEATS);
            mem_rdata = mem_resp ? base + DATA_W'(sent) : 16'hdead;
            #1;
            check("rd_grant", grant_v[c], 1'b1);
            check("rd_other", {grant_v[1-c], beat_v[1-c], done_v[1-c], err_v[1-c], rdata_of(1 - c)}, 0);
            check("rd_mem_cmd", mem_cmd, CMD_NOP);
            check("rd_beat", beat_v[c], mem_resp);
            check("rd_err", err_v[c], 1'b0);
            if (mem_resp) begin
                check("rd_rdata", rdata_of(c), exp_q.pop_front());
                sent++;
            end
            if (beat_v[c]) got++;
            if (done_v[c]) done_k = k;
        end
        mem_resp = 1'b0;
        check("rd_done_cycle", done_k, delay + BEATS);
        check("rd_beat_count", got, BEATS);
        step();
        check("rd_after_grant", grant_v, 2'b00);
        check("rd_after_done", done_v, 2'b00);
    endtask

    // Full write burst for client c; the ack arrives `ack_delay` cycles after the last beat.
    task automatic write_burst(input int c, input logic [ADDR_W-1:0] addr, input int ack_delay,
                               input logic [DATA_W-1:0] base);
        int done_k;
        set_cmd(c, CMD_WRITE, addr);
        set_wdata(c, base);
        #1;
        check("wr_idle_grant", grant_v, 2'b00);
        step();
        set_cmd(c, CMD_NOP, addr);
        #1;
        check("wr_cmd_grant", grant_v, (c == 0) ? 2'b01 : 2'b10);
        check("wr_cmd_mem_cmd", mem_cmd, CMD_WRITE);
        check("wr_cmd_addr", mem_addr, addr);
        for (int i = 0; i < BEATS; i++) begin
            step();
            set_wdata(c, base + DATA_W'(i));
            mem_resp = (i == 2);
            #1;
            check("wr_mem_cmd", mem_cmd, CMD_WRITE);
            check("wr_mem_wdata", mem_wdata, base + DATA_W'(i));
            check("wr_beat", beat_v[c], 1'b1);
            check("wr_other", {grant_v[1-c], beat_v[1-c], done_v[1-c]}, 0);
        end
        mem_resp = 1'b0;
        done_k   = 0;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            step();
            mem_resp = (k == ack_delay);
            #1;
            check("wr_wait_mem_cmd", mem_cmd, CMD_NOP);
            check("wr_wait_addr", mem_addr, addr);
            check("wr_wait_beat", beat_v[c], 1'b0);
            check("wr_wait_grant", grant_v[c], 1'b1);
            if (done_v[c]) done_k = k;
        end
        mem_resp = 1'b0;
        check("wr_done_cycle", done_k, ack_delay + 1);
        step();
        check("wr_after_grant", grant_v, 2'b00);
    endtask

    initial begin
        reset     = 1'b1;
        m0_cmd    = CMD_NOP;
        m1_cmd    = CMD_NOP;
        m0_addr   = '0;
        m1_addr   = '0;
        m0_wdata  = '0;
        m1_wdata  = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
        #2;
        check("rst_grant", grant_v, 2'b00);
        check("rst_mem_cmd", mem_cmd, CMD_NOP);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_flags", {beat_v, done_v, err_v}, 0);
        step();
        step();
        reset = 1'b0;

        read_burst(0, 14'h0123, 2, 16'h1000, 1'b0);
        write_burst(1, 14'h0abc, 3, 16'ha000);

        // Ties after m1 was granted last: expect 0, 1, 0.
        read_burst(0, 14'h0200, 1, 16'h2000, 1'b1);
        read_burst(1, 14'h0300, 1, 16'h3000, 1'b1);
        read_burst(0, 14'h0400, 1, 16'h4000, 1'b1);

        // Reset during write beat 4 aborts the burst with no done.
        set_cmd(0, CMD_WRITE, 14'h0555);
        set_wdata(0, 16'hb000);
        step();
        set_cmd(0, CMD_NOP, 14'h0555);
        for (int i = 0; i < 5; i++) step();
        check("abort_pre_mem_cmd", mem_cmd, CMD_WRITE);
        reset = 1'b1;
        #1;
        check("abort_mem_cmd", mem_cmd, CMD_NOP);
        check("abort_grant", grant_v, 2'b00);
        check("abort_done", done_v, 2'b00);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_idle", {grant_v, done_v, mem_cmd}, 0);
        end
        read_burst(0, 14'h0042, 1, 16'h5000, 1'b0);

        // Illegal command code is never granted.
        m0_cmd = CMD_RESP;
        for (int i = 0; i < 5; i++) begin
            step();
            check("illegal_grant", grant_v, 2'b00);
            check("illegal_mem_cmd", mem_cmd, CMD_NOP);
        end
        m0_cmd = CMD_NOP;
        step();

`ifdef ARB_TIMEOUT_EN
        begin
            int done_k;
            logic err_seen;
            set_cmd(0, CMD_READ, 14'h0777);
            step();
            set_cmd(0, CMD_NOP, 14'h0777);
            done_k   = 0;
            err_seen = 1'b0;
            for (int k = 1; k <= 40 && done_k == 0; k++) begin
                step();
                if (m0_done) begin
                    done_k   = k;
                    err_seen = m0_err;
                end else begin
                    check("to_err_early", m0_err, 1'b0);
                end
            end
            check("to_done_cycle", done_k, TIMEOUT + 1);
            check("to_err", err_seen, 1'b1);
            step();
            check("to_idle_grant", grant_v, 2'b00);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
